risc_pipe_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RISC core: fetch (F), decode (D), execute (X), memory (Y) and writeback (R). It keeps a registered record of the instructions in X, Y and R. From that record it drives the ALU operand forwarding selects, load-use stalls, taken-branch flushes and whole-pipe freezes while data memory is busy. It also keeps two saturating performance counters.

---
 rtl/risc_pkg.sv | 44 ++++
 rtl/risc_instr_decode.sv | 49 ++++
 rtl/risc_pipe_ctrl.sv | 97 +++++++++
 tb/tb_risc_pipe_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared types for the pipeline hazard controller: opcodes, the per-stage
// instruction record and the forwarding-select encoding.
package risc_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM_OP = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       is_load;
    logic [4:0] rs1;
    logic       use1;
    logic [4:0] rs2;
    logic       use2;
  } stage_rec_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_Y  = 2'b01,
    FWD_R  = 2'b10
  } fwd_sel_t;

  // Y is the newer producer so it wins; a load in Y has no result yet.
  function automatic fwd_sel_t fwd_pick(input logic [4:0] rs, input logic en,
                                        input stage_rec_t y, input stage_rec_t r);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (en && y.valid && y.wr && !y.is_load && (y.rd == rs))
      sel = FWD_Y;
    else if (en && r.valid && r.wr && (r.rd == rs))
      sel = FWD_R;
    return sel;
  endfunction

endpackage

// File: rtl/risc_instr_decode.sv
// Combinational decode of the D-stage instruction into a stage record.
// Unknown opcodes and invalid slots decode to an all-zero bubble.
module risc_instr_decode
  import risc_pkg::*;
(
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  output stage_rec_t  rec
);

  logic [6:0] opc;
  logic       known;
  logic       rd1;
  logic       rd2;
  logic       writes;
  logic       unused_bits;

  assign opc         = instr_d[6:0];
  assign unused_bits = ^{instr_d[31:25], instr_d[14:12]};

  always_comb begin
    known  = 1'b1;
    rd1    = 1'b0;
    rd2    = 1'b0;
    writes = 1'b1;
    case (opc)
      OPC_OP:                        begin rd1 = 1'b1; rd2 = 1'b1; end
      OPC_BRANCH, OPC_STORE:         begin rd1 = 1'b1; rd2 = 1'b1; writes = 1'b0; end
      OPC_IMM_OP, OPC_LOAD, OPC_JALR: rd1 = 1'b1;
      OPC_LUI, OPC_AUIPC, OPC_JAL:   ;
      default:                       known = 1'b0;
    endcase
  end

  always_comb begin
    rec = '0;
    if (valid_d && known) begin
      rec.valid   = 1'b1;
      rec.rd      = instr_d[11:7];
      rec.wr      = writes && (instr_d[11:7] != 5'd0);
      rec.is_load = (opc == OPC_LOAD);
      rec.rs1     = instr_d[19:15];
      rec.use1    = rd1;
      rec.rs2     = instr_d[24:20];
      rec.use2    = rd2;
    end
  end

endmodule

// File: rtl/risc_pipe_ctrl.sv
// Hazard controller for the five-stage pipe: tracks X/Y/R records and drives
// forwarding selects, load-use stalls, branch flushes and memory freezes.
module risc_pipe_ctrl
  import risc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_d,
  input  logic             valid_d,
  input  logic             branch_taken_x,
  input  logic             mem_busy,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             bubble_x,
  output logic             hold_xyr,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_rec_t rec_d;
  stage_rec_t st_x;
  stage_rec_t st_y;
  stage_rec_t st_r;
  logic       init_q;
  logic       blocked;
  logic       mb_eff;
  logic       br_eff;
  logic       lu;
  logic       unused_r;

  risc_instr_decode u_dec (
    .instr_d (instr_d),
    .valid_d (valid_d),
    .rec     (rec_d)
  );

  // Controls stay quiet during reset and the first cycle out of it.
  assign blocked = rst | init_q;
  assign mb_eff  = mem_busy & ~blocked;
  assign br_eff  = branch_taken_x & ~blocked;

  assign lu = st_x.valid & st_x.is_load & st_x.wr & valid_d &
              ((rec_d.use1 & (rec_d.rs1 == st_x.rd)) |
               (rec_d.use2 & (rec_d.rs2 == st_x.rd)));

  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    bubble_x = 1'b0;
    hold_xyr = 1'b0;
    if (mb_eff) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      hold_xyr = 1'b1;
    end else if (br_eff) begin
      flush_d  = 1'b1;
      bubble_x = 1'b1;
    end else if (lu) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      bubble_x = 1'b1;
    end
  end

  assign fwd_a_sel = fwd_pick(st_x.rs1, st_x.use1, st_y, st_r);
  assign fwd_b_sel = fwd_pick(st_x.rs2, st_x.use2, st_y, st_r);
  assign unused_r  = ^{st_r.is_load, st_r.rs1, st_r.use1, st_r.rs2, st_r.use2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_x      <= '0;
      st_y      <= '0;
      st_r      <= '0;
      init_q    <= 1'b1;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      init_q <= 1'b0;
      if (!mb_eff) begin
        st_r <= st_y;
        st_y <= st_x;
        st_x <= (bubble_x || !valid_d) ? '0 : rec_d;
      end
      if (lu && !mb_eff && !br_eff && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (br_eff && !mb_eff && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_risc_pipe_ctrl.sv
// Directed bench for risc_pipe_ctrl: hand-computed control, forwarding and
// counter values across ALU, load-use, x0, branch, freeze and saturation cases.
module tb_risc_pipe_ctrl;
  import risc_pkg::*;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [31:0]      instr_d;
  logic             valid_d;
  logic             branch_taken_x;
  logic             mem_busy;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             bubble_x;
  logic             hold_xyr;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks   = 0;
  int failures = 0;

  risc_pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_d        (instr_d),
    .valid_d        (valid_d),
    .branch_taken_x (branch_taken_x),
    .mem_busy       (mem_busy),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .bubble_x       (bubble_x),
    .hold_xyr       (hold_xyr),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc(input logic [6:0] opc, input int rd,
                                      input int rs1, input int rs2);
    return {7'd0, rs2[4:0], rs1[4:0], 3'd0, rd[4:0], opc};
  endfunction

  // driver tasks
  task automatic drv(input logic [31:0] ins, input logic v, input logic br,
                     input logic mb);
    instr_d        = ins;
    valid_d        = v;
    branch_taken_x = br;
    mem_busy       = mb;
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {stall_f, stall_d, flush_d, bubble_x, hold_xyr}
  task automatic chk_ctrl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, stall_f, stall_d, flush_d, bubble_x, hold_xyr}, {27'd0, exp});
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk(tag, {28'd0, fwd_a_sel, fwd_b_sel}, {28'd0, a, b});
  endtask

  // A consumer in X must never be matched against a load still in Y.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(dut.st_y.valid && dut.st_y.wr && dut.st_y.is_load &&
               ((dut.st_x.use1 && dut.st_x.rs1 == dut.st_y.rd) ||
                (dut.st_x.use2 && dut.st_x.rs2 == dut.st_y.rd)))) else begin
        failures++;
        $error("FAIL load_in_y_match observed=1 expected=0");
      end
    end
  end

  initial begin
    // reset with branch and mem_busy asserted: everything must stay quiet
    rst = 1'b1;
    drv(32'd0, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk_ctrl("rst_ctrl", 5'b00000);
    chk_fwd("rst_fwd", 2'b00, 2'b00);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk_ctrl("init_ctrl", 5'b00000);
    adv();
    drv(32'd0, 1'b0, 1'b0, 1'b0);
    chk("init_flush_cnt", 32'(flush_cnt), 32'd0);

    // back-to-back ALU: add x5,x1,x2 ; sub x6,x5,x3
    drv(enc(OPC_OP, 5, 1, 2), 1'b1, 1'b0, 1'b0);
    chk_ctrl("alu_add_ctrl", 5'b00000);
    adv();
    drv(enc(OPC_OP, 6, 5, 3), 1'b1, 1'b0, 1'b0);
    chk_ctrl("alu_sub_ctrl", 5'b00000);
    chk_fwd("alu_add_in_x_fwd", 2'b00, 2'b00);
    adv();
    drv(32'd0, 1'b0, 1'b0, 1'b0);
    chk_fwd("alu_sub_in_x_fwd", 2'b01, 2'b00);
    chk_ctrl("alu_sub_in_x_ctrl", 5'b00000);
    adv();
    chk_fwd("alu_drain_fwd", 2'b00, 2'b00);
    adv();

    // load-use: lw x7,0(x1) ; add x8,x7,x7
    drv(enc(OPC_LOAD, 7, 1, 0), 1'b1, 1'b0, 1'b0);
    chk_ctrl("lu_lw_ctrl", 5'b00000);
    adv();
    drv(enc(OPC_OP, 8, 7, 7), 1'b1, 1'b0, 1'b0);
    chk_ctrl("lu_stall_ctrl", 5'b11010);
    chk("lu_stall_cnt_pre", 32'(stall_cnt), 32'd0);
    adv();
    chk_ctrl("lu_release_ctrl", 5'b00000);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    adv();
    drv(32'd0, 1'b0, 1'b0, 1'b0);
    chk_fwd("lu_add_in_x_fwd", 2'b10, 2'b10);
    adv();

    // writes to x0: addi x0,x0,5 ; add x9,x0,x0 ; lw x0,0(x1) ; add x9,x0,x0
    drv(enc(OPC_IMM_OP, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    adv();
    drv(enc(OPC_OP, 9, 0, 0), 1'b1, 1'b0, 1'b0);
    chk_ctrl("x0_add_ctrl", 5'b00000);
    adv();
    drv(enc(OPC_LOAD, 0, 1, 0), 1'b1, 1'b0, 1'b0);
    chk_fwd("x0_add_in_x_fwd", 2'b00, 2'b00);
    adv();
    drv(enc(OPC_OP, 9, 0, 0), 1'b1, 1'b0, 1'b0);
    chk_ctrl("x0_load_no_stall", 5'b00000);
    adv();
    drv(32'd0, 1'b0, 1'b0, 1'b0);
    chk_fwd("x0_load_fwd", 2'b00, 2'b00);
    adv();
    adv();
    chk("x0_stall_cnt", 32'(stall_cnt), 32'd1);

    // taken branch while a load-use hazard is pending
    drv(enc(OPC_LOAD, 10, 1, 0), 1'b1, 1'b0, 1'b0);
    adv();
    drv(enc(OPC_OP, 11, 10, 2), 1'b1, 1'b1, 1'b0);
    chk_ctrl("br_lu_ctrl", 5'b00110);
    adv();
    drv(32'd0, 1'b0, 1'b0, 1'b0);
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd1);
    chk_ctrl("br_after_ctrl", 5'b00000);
    adv();

    // memory freeze over a load-use pair, branch ignored mid-freeze
    drv(enc(OPC_LOAD, 12, 1, 0), 1'b1, 1'b0, 1'b0);
    adv();
    for (int i = 0; i < 3; i++) begin
      drv(enc(OPC_OP, 13, 12, 12), 1'b1, (i == 1), 1'b1);
      chk_ctrl($sformatf("frz_ctrl_%0d", i), 5'b11001);
      chk($sformatf("frz_stx_rd_%0d", i), 32'(dut.st_x.rd), 32'd12);
      chk($sformatf("frz_stx_load_%0d", i), 32'(dut.st_x.is_load), 32'd1);
      chk($sformatf("frz_stall_cnt_%0d", i), 32'(stall_cnt), 32'd1);
      adv();
    end
    drv(enc(OPC_OP, 13, 12, 12), 1'b1, 1'b0, 1'b0);
    chk_ctrl("frz_resume_ctrl", 5'b11010);
    chk("frz_flush_cnt", 32'(flush_cnt), 32'd1);
    adv();
    chk_ctrl("frz_release_ctrl", 5'b00000);
    chk("frz_stall_cnt", 32'(stall_cnt), 32'd2);
    adv();
    drv(32'd0, 1'b0, 1'b0, 1'b0);
    chk_fwd("frz_add_in_x_fwd", 2'b10, 2'b10);
    adv();

    // reset asserted during a freeze
    drv(enc(OPC_LOAD, 14, 1, 0), 1'b1, 1'b0, 1'b0);
    adv();
    drv(enc(OPC_OP, 15, 14, 0), 1'b1, 1'b0, 1'b1);
    chk_ctrl("rstfrz_pre_ctrl", 5'b11001);
    rst = 1'b1;
    #1;
    chk_ctrl("rstfrz_ctrl", 5'b00000);
    chk_fwd("rstfrz_fwd", 2'b00, 2'b00);
    chk("rstfrz_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rstfrz_flush_cnt", 32'(flush_cnt), 32'd0);
    adv();
    rst = 1'b0;
    #1;
    chk_ctrl("rstfrz_init_ctrl", 5'b00000);
    adv();
    drv(32'd0, 1'b0, 1'b0, 1'b0);
    chk("rstfrz_after_stall_cnt", 32'(stall_cnt), 32'd0);
    adv();

    // flush counter saturation at 15 with CNT_W = 4
    for (int i = 0; i < 15; i++) begin
      drv(32'd0, 1'b0, 1'b1, 1'b0);
      adv();
    end
    chk("sat_flush_cnt_15", 32'(flush_cnt), 32'd15);
    for (int i = 0; i < 5; i++) begin
      drv(32'd0, 1'b0, 1'b1, 1'b0);
      chk_ctrl($sformatf("sat_ctrl_%0d", i), 5'b00110);
      adv();
    end
    drv(32'd0, 1'b0, 1'b0, 1'b0);
    chk("sat_flush_cnt_20", 32'(flush_cnt), 32'd15);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd0);
    adv();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
